softmax_row_stream: RTL and testbench

Streaming, parametrised softmax engine for rows longer than one data word. It accepts a row as 1..MAX_BEATS beats of LANES Q8.8 values and buffers the row internally while tracking the running max. It then computes log2-domain exponents and their sum, and emits LANES Q1.15 probabilities per beat over a valid/ready output. It is the multi-beat, back-pressured successor to the fixed 64-lane mode-switched softmax.

---
 rtl/softmax_row_stream.sv | 177 +++++++++++++++++
 tb/tb_softmax_row_stream.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/softmax_row_stream.sv
// rtl/softmax_row_stream.sv - multi-beat streaming softmax, Q8.8 in, Q1.15 out
// Buffers a row, folds log2(e) into in-place exponents, then normalises in the log2 domain.
module softmax_row_stream #(
  parameter int LANES     = 16,
  parameter int MAX_BEATS = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [LANES*16-1:0] i_data,
  input  logic                i_last,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [LANES*16-1:0] o_data,
  output logic                o_last,
  output logic                o_ovf,
  output logic                o_busy
);

  localparam int SUM_W = 16 + $clog2(LANES * MAX_BEATS);
  localparam int EW    = 16 + $clog2(LANES);
  localparam int AW    = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam int CW    = AW + 1;

  typedef enum logic [1:0] {S_LOAD, S_EXP, S_LOG, S_OUT} state_t;

  // v is signed Q8.8 and never positive; the shift count is -floor(v)
  function automatic logic [15:0] f_exp2(input logic [15:0] v);
    logic [7:0]  s;
    logic [15:0] mant;
    s    = 8'd0 - v[15:8];
    mant = {1'b1, v[7:0], 7'd0};
    if (s >= 8'd16) return 16'd0;
    return mant >> s[3:0];
  endfunction

  state_t              r_state;
  logic                r_ready;
  logic                r_valid;
  logic                r_last;
  logic                r_ovf;
  logic                r_busy;
  logic [CW-1:0]       r_cnt;
  logic [CW-1:0]       r_ptr;
  logic [15:0]         r_m;
  logic [SUM_W-1:0]    r_sum;
  logic [15:0]         r_l;
  logic [LANES*16-1:0] r_buf [MAX_BEATS];

  logic                w_in_fire;
  logic [LANES*16-1:0] w_row;
  logic [LANES*16-1:0] w_y;
  logic [LANES*16-1:0] w_out;
  logic [EW-1:0]       w_esum;
  logic [15:0]         w_bmax;
  logic [7:0]          w_lp;
  logic [SUM_W-1:0]    w_sh;
  logic [15:0]         w_lval;

  assign w_in_fire = i_valid && r_ready && (r_state == S_LOAD);

  always_comb begin
    logic [15:0] x;
    logic [15:0] y;
    logic [16:0] d;
    logic [16:0] diff;
    logic [17:0] a;
    w_row  = r_buf[r_ptr[AW-1:0]];
    w_y    = '0;
    w_out  = '0;
    w_esum = '0;
    w_bmax = i_data[15:0];
    x      = '0;
    y      = '0;
    d      = '0;
    diff   = '0;
    a      = '0;
    for (int k = 0; k < LANES; k++) begin
      if ($signed(i_data[k*16+:16]) > $signed(w_bmax)) w_bmax = i_data[k*16+:16];
      x = w_row[k*16+:16];
      d = {r_m[15], r_m} - {x[15], x};
      a = {1'b0, d} + {2'b0, d[16:1]} - {5'b0, d[16:4]};
      y = (a >= 18'd32768) ? 16'h8000 : 16'd0 - a[15:0];
      w_y[k*16+:16] = y;
      w_esum = w_esum + EW'(f_exp2(y));
      // buffered y minus L, saturated at the bottom of the Q8.8 range
      diff = {x[15], x} - {1'b0, r_l};
      w_out[k*16+:16] = f_exp2((diff[16] && !diff[15]) ? 16'h8000 : diff[15:0]);
    end
  end

  always_comb begin
    w_lp = 8'd15;
    for (int i = 16; i < SUM_W; i++) begin
      if (r_sum[i]) w_lp = 8'(i);
    end
    w_sh   = r_sum >> (w_lp - 8'd8);
    w_lval = {w_lp - 8'd15, w_sh[7:0]};
  end

  always_ff @(posedge i_clk) begin
    if (w_in_fire) r_buf[r_cnt[AW-1:0]] <= i_data;
    else if (r_state == S_EXP) r_buf[r_ptr[AW-1:0]] <= w_y;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_LOAD;
      r_ready <= 1'b1;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_ptr   <= '0;
      r_m     <= '0;
      r_sum   <= '0;
      r_l     <= '0;
    end else begin
      r_ovf <= 1'b0;
      case (r_state)
        S_LOAD: begin
          if (w_in_fire) begin
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == '0 || $signed(w_bmax) > $signed(r_m)) r_m <= w_bmax;
            if (i_last || r_cnt == CW'(MAX_BEATS - 1)) begin
              r_state <= S_EXP;
              r_ready <= 1'b0;
              r_busy  <= 1'b1;
              r_ptr   <= '0;
              r_sum   <= '0;
              r_ovf   <= !i_last;
            end
          end
        end
        S_EXP: begin
          r_sum <= r_sum + SUM_W'(w_esum);
          r_ptr <= r_ptr + CW'(1);
          if (r_ptr == r_cnt - CW'(1)) r_state <= S_LOG;
        end
        S_LOG: begin
          r_l     <= w_lval;
          r_ptr   <= '0;
          r_valid <= 1'b1;
          r_last  <= (r_cnt == CW'(1));
          r_state <= S_OUT;
        end
        S_OUT: begin
          if (i_ready) begin
            if (r_last) begin
              r_state <= S_LOAD;
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_ready <= 1'b1;
              r_busy  <= 1'b0;
              r_cnt   <= '0;
              r_ptr   <= '0;
            end else begin
              r_ptr  <= r_ptr + CW'(1);
              r_last <= (r_ptr + CW'(2) == r_cnt);
            end
          end
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end

  assign o_ready = r_ready;
  assign o_valid = r_valid;
  assign o_last  = r_last;
  assign o_ovf   = r_ovf;
  assign o_busy  = r_busy;
  assign o_data  = w_out;

endmodule

// File: tb/tb_softmax_row_stream.sv
// tb/tb_softmax_row_stream.sv - directed checks of softmax_row_stream with hand-computed vectors
module tb_softmax_row_stream;
  localparam int LANES = 16;
  localparam int MAX_BEATS = 8;
  localparam int DW = LANES * 16;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_valid = 1'b0;
  logic          i_last = 1'b0;
  logic          i_ready = 1'b0;
  logic [DW-1:0] i_data = '0;
  logic          o_ready;
  logic          o_valid;
  logic          o_last;
  logic          o_ovf;
  logic          o_busy;
  logic [DW-1:0] o_data;

  int n_cmp = 0;
  int n_err = 0;
  logic [DW-1:0] beats [0:8];
  logic [DW-1:0] expb [0:8];

  softmax_row_stream #(.LANES(LANES), .MAX_BEATS(MAX_BEATS)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_data(i_data), .i_last(i_last), .o_valid(o_valid), .i_ready(i_ready),
    .o_data(o_data), .o_last(o_last), .o_ovf(o_ovf), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int nb, input bit with_last);
    for (int b = 0; b < nb; b++) begin
      @(negedge i_clk);
      i_valid = 1'b1;
      i_data  = beats[b];
      i_last  = with_last && (b == nb - 1);
      chk("in_ready", o_ready, 1);
      @(posedge i_clk);
    end
  endtask

  task automatic wait_valid(input int exp_lat, input string tag);
    int c = 0;
    do begin
      @(negedge i_clk);
      i_valid = 1'b0;
      i_last  = 1'b0;
      c++;
    end while (!o_valid && c < 40);
    chk(tag, c, exp_lat);
  endtask

  task automatic recv(input int nb, input bit bp, input string tag);
    i_ready = 1'b1;
    for (int b = 0; b < nb; b++) begin
      if (b > 0) @(negedge i_clk);
      chk({tag, "_valid"}, o_valid, 1);
      chk({tag, "_data"}, o_data, expb[b]);
      chk({tag, "_last"}, o_last, b == nb - 1);
      if (bp && b == 1) begin
        i_ready = 1'b0;
        repeat (5) begin
          @(negedge i_clk);
          chk("bp_valid", o_valid, 1);
          chk("bp_data", o_data, expb[b]);
          chk("bp_last", o_last, b == nb - 1);
        end
        i_ready = 1'b1;
      end
      @(posedge i_clk);
    end
    @(negedge i_clk);
    i_ready = 1'b0;
    chk({tag, "_valid_drop"}, o_valid, 0);
    chk({tag, "_ready_rise"}, o_ready, 1);
    chk({tag, "_busy_drop"}, o_busy, 0);
  endtask

  initial begin
    repeat (3) @(negedge i_clk);
    chk("rst_valid", o_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_ovf", o_ovf, 0);
    chk("rst_last", o_last, 0);
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("rst_ready", o_ready, 1);

    // one all-zero beat: S=2^19, L=0x0400, each lane 1/16
    beats[0] = {16{16'h0000}};
    expb[0]  = {16{16'h0800}};
    send(1, 1'b1);
    wait_valid(3, "lat_1beat");
    recv(1, 1'b0, "zero1");

    // one dominant lane, the rest saturate to zero weight
    beats[0] = {{15{16'h8000}}, 16'h0100};
    expb[0]  = {{15{16'h0000}}, 16'h8000};
    send(1, 1'b1);
    wait_valid(3, "lat_dom");
    recv(1, 1'b0, "dom");

    // lane0 = 1.0, lane1 = 0.0: S=0xB200, L=0x0064
    beats[0] = {{14{16'h8000}}, 16'h0000, 16'h0100};
    expb[0]  = {{14{16'h0000}}, 16'h2580, 16'h6700};
    send(1, 1'b1);
    wait_valid(3, "lat_frac");
    recv(1, 1'b0, "frac");

    // two all-zero beats: L=0x0500
    beats[0] = {16{16'h0000}};
    beats[1] = {16{16'h0000}};
    expb[0]  = {16{16'h0400}};
    expb[1]  = {16{16'h0400}};
    send(2, 1'b1);
    wait_valid(4, "lat_2beat");
    recv(2, 1'b0, "zero2");

    // three beats, middle beat half-saturated: S=40*2^15, L=0x0540, stalled output
    beats[0] = {16{16'h0000}};
    beats[1] = {8{16'h8000, 16'h0000}};
    beats[2] = {16{16'h0000}};
    expb[0]  = {16{16'h0380}};
    expb[1]  = {8{16'h0000, 16'h0380}};
    expb[2]  = {16{16'h0380}};
    send(3, 1'b1);
    wait_valid(5, "lat_3beat");
    recv(3, 1'b1, "bp");

    // nine beats without i_last: truncated at MAX_BEATS, 1/128 per lane
    for (int b = 0; b < MAX_BEATS; b++) begin
      @(negedge i_clk);
      i_valid = 1'b1;
      i_data  = '0;
      i_last  = 1'b0;
      chk("ovf_in_ready", o_ready, 1);
      @(posedge i_clk);
    end
    @(negedge i_clk);
    chk("ovf_pulse", o_ovf, 1);
    chk("ovf_block_9th", o_ready, 0);
    @(negedge i_clk);
    chk("ovf_once", o_ovf, 0);
    for (int b = 0; b < MAX_BEATS; b++) expb[b] = {16{16'h0100}};
    wait_valid(8, "lat_ovf");
    recv(MAX_BEATS, 1'b0, "ovf");

    // reset during EXP aborts the row
    beats[0] = {16{16'h0000}};
    beats[1] = {16{16'h0000}};
    send(2, 1'b1);
    @(negedge i_clk);
    i_valid = 1'b0;
    i_last  = 1'b0;
    chk("abort_busy_exp", o_busy, 1);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    chk("abort_valid", o_valid, 0);
    chk("abort_busy", o_busy, 0);
    chk("abort_ready", o_ready, 1);
    repeat (6) begin
      @(negedge i_clk);
      chk("abort_quiet", o_valid, 0);
    end
    beats[0] = {16{16'h0000}};
    expb[0]  = {16{16'h0800}};
    send(1, 1'b1);
    wait_valid(3, "lat_after_abort");
    recv(1, 1'b0, "after_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
